trig_unit_sequencer: RTL

//  Sequences the multi-cycle trig unit that produces trigResult in the EXE stage.

---
 rtl/stages_definition_pkg.sv | 14 +
 rtl/watchdog_counter.sv | 31 +++
 rtl/trig_unit_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/stages_definition_pkg.sv
// Shared pipeline-stage definitions: trig sequencer state encoding and limits.
package stages_definition_pkg;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_BUSY,
        TS_DONE,
        TS_DRAIN
    } trig_seq_state_e;

    localparam int TRIG_MAX_CYCLES = 32;
    localparam int TRIG_WIDTH      = 32;

endpackage

// File: rtl/watchdog_counter.sv
// Cycle counter with synchronous clear, count enable and terminal-count decode.
// Saturates at MAX_CYCLES-1 so the compare can never wrap past the limit.
module watchdog_counter
    import stages_definition_pkg::*;
#(
    parameter int MAX_CYCLES = TRIG_MAX_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    localparam int unsigned CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

    logic [CW-1:0] count;

    assign terminal_c = (count == CW'(MAX_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal_c) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/trig_unit_sequencer.sv
// Sequences the multi-cycle trig unit in EXE: start pulse, pipeline freeze/bubble,
// flush draining of an in-flight operation and a watchdog forced completion.
module trig_unit_sequencer
    import stages_definition_pkg::*;
#(
    parameter int WIDTH      = TRIG_WIDTH,
    parameter int MAX_CYCLES = TRIG_MAX_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exe_valid,
    input  logic             trig_select,
    input  logic             flush,
    input  logic             trig_done,
    input  logic [WIDTH-1:0] trig_data,
    output logic             trig_start,
    output logic             stall_fetch,
    output logic             stall_deco,
    output logic             stall_exe,
    output logic             bubble_mem,
    output logic [WIDTH-1:0] trig_result,
    output logic             result_valid,
    output logic             timeout_err
);

    trig_seq_state_e state_q;
    trig_seq_state_e state_d;

    logic req;
    logic stall;
    logic wd_clear;
    logic wd_enable;
    logic wd_terminal;
    logic result_load;
    logic result_clear;
    logic timeout_set;

    // Reset gates the Mealy request so all outputs drop the moment rst rises.
    assign req = exe_valid & trig_select & ~flush & ~rst;

    assign stall_fetch = stall;
    assign stall_deco  = stall;
    assign stall_exe   = stall;
    assign bubble_mem  = stall;

    watchdog_counter #(
        .MAX_CYCLES(MAX_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .clear      (wd_clear),
        .enable     (wd_enable),
        .terminal_c (wd_terminal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush takes priority over a coincident done or timeout in BUSY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TS_IDLE: begin
                if (req) begin
                    state_d = TS_BUSY;
                end
            end
            TS_BUSY: begin
                if (flush) begin
                    state_d = trig_done ? TS_IDLE : TS_DRAIN;
                end else if (trig_done || wd_terminal) begin
                    state_d = TS_DONE;
                end
            end
            TS_DONE: begin
                state_d = TS_IDLE;
            end
            TS_DRAIN: begin
                if (trig_done || wd_terminal) begin
                    state_d = TS_IDLE;
                end
            end
            default: begin
                state_d = TS_IDLE;
            end
        endcase
    end

    always_comb begin
        trig_start   = 1'b0;
        stall        = 1'b0;
        result_valid = 1'b0;
        wd_clear     = 1'b0;
        wd_enable    = 1'b0;
        result_load  = 1'b0;
        result_clear = 1'b0;
        timeout_set  = 1'b0;
        case (state_q)
            TS_IDLE: begin
                wd_clear = 1'b1;
                if (req) begin
                    trig_start = 1'b1;
                    stall      = 1'b1;
                end
            end
            TS_BUSY: begin
                stall     = 1'b1;
                wd_enable = 1'b1;
                if (!flush) begin
                    if (trig_done) begin
                        result_load = 1'b1;
                    end else if (wd_terminal) begin
                        result_clear = 1'b1;
                        timeout_set  = 1'b1;
                    end
                end
            end
            TS_DONE: begin
                result_valid = 1'b1;
                wd_clear     = 1'b1;
            end
            TS_DRAIN: begin
                // A refilled trig instruction waits here until the stale done returns.
                stall     = req;
                wd_enable = 1'b1;
                if (!trig_done && wd_terminal) begin
                    timeout_set = 1'b1;
                end
            end
            default: begin
                wd_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_result <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (result_load) begin
                trig_result <= trig_data;
            end else if (result_clear) begin
                trig_result <= '0;
            end
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
